// File: rtl/nesctrl_scan.sv
// nesctrl_scan: NES dual-pad 4021 scan sequencer; define NESCTRL_DEBOUNCE_EN for two-scan agreement filtering
module nesctrl_scan #(
  parameter int DIV = 4,
  parameter int POLL_PERIOD = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       scan_req,
  input  logic       nesctrl_ctrl1_q7,
  input  logic       nesctrl_ctrl2_q7,
  output logic       nesctrl_pl,
  output logic       nesctrl_clk,
  output logic [7:0] nesctrl_ctrl1_data,
  output logic [7:0] nesctrl_ctrl2_data,
  output logic       data_valid,
  output logic       busy
);
  localparam int CW = $clog2(2 * DIV) + 1;
  localparam int PW = $clog2(POLL_PERIOD) + 1;
  typedef enum logic [2:0] {IDLE, LATCH, SAMPLE, CLK_HI, DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [PW-1:0] poll;
  logic [2:0] idx;
  logic [1:0] s1, s2;
  logic [7:0] sr1, sr2, sr1_n, sr2_n, d1_n, d2_n;
  logic wrap, start, last, cap;
  always_comb begin
    wrap = poll == PW'(POLL_PERIOD - 1);
    start = (wrap && en) || scan_req;
    last = cnt == ((state == LATCH) ? CW'(2 * DIV - 1) : CW'(DIV - 1));
    cap = state == SAMPLE && last;
    sr1_n = sr1;
    sr2_n = sr2;
    if (cap) begin
      sr1_n[idx] = ~s1[1];
      sr2_n[idx] = ~s2[1];
    end
    state_n = state;
    case (state)
      IDLE:    state_n = start ? LATCH : IDLE;
      LATCH:   state_n = last ? SAMPLE : LATCH;
      SAMPLE:  state_n = last ? ((idx == 3'd7) ? DONE : CLK_HI) : SAMPLE;
      CLK_HI:  state_n = last ? SAMPLE : CLK_HI;
      default: state_n = IDLE;
    endcase
  end
`ifdef NESCTRL_DEBOUNCE_EN
  logic [7:0] prev1, prev2;
  always_comb begin
    d1_n = (sr1_n & ~(sr1_n ^ prev1)) | (nesctrl_ctrl1_data & (sr1_n ^ prev1));
    d2_n = (sr2_n & ~(sr2_n ^ prev2)) | (nesctrl_ctrl2_data & (sr2_n ^ prev2));
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev1 <= '0;
      prev2 <= '0;
    end else if (state_n == DONE) begin
      prev1 <= sr1_n;
      prev2 <= sr2_n;
    end
  end
`else
  always_comb begin
    d1_n = sr1_n;
    d2_n = sr2_n;
  end
`endif
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      poll <= '0;
      idx <= '0;
      s1 <= '0;
      s2 <= '0;
      sr1 <= '0;
      sr2 <= '0;
      nesctrl_pl <= 1'b0;
      nesctrl_clk <= 1'b0;
      busy <= 1'b0;
      data_valid <= 1'b0;
      nesctrl_ctrl1_data <= '0;
      nesctrl_ctrl2_data <= '0;
    end else begin
      state <= state_n;
      cnt <= (state_n != state || state == IDLE) ? '0 : cnt + 1'b1;
      poll <= wrap ? '0 : poll + 1'b1;
      idx <= (state == CLK_HI && last) ? idx + 3'd1 : (state == LATCH ? 3'd0 : idx);
      s1 <= {s1[0], nesctrl_ctrl1_q7};
      s2 <= {s2[0], nesctrl_ctrl2_q7};
      sr1 <= sr1_n;
      sr2 <= sr2_n;
      nesctrl_pl <= state_n == LATCH;
      nesctrl_clk <= state_n == CLK_HI;
      busy <= state_n != IDLE;
      data_valid <= state_n == DONE;
      if (state_n == DONE) begin
        nesctrl_ctrl1_data <= d1_n;
        nesctrl_ctrl2_data <= d2_n;
      end
    end
  end
endmodule

// File: doc/nesctrl_scan.md
Name: nesctrl_scan

Overview:
- Sequencer for the two NES gamepad 4021 shift registers on the shared nesctrl_pl / nesctrl_clk lines.
- Polls both pads periodically or on request, shifts out 8 buttons from each pad in parallel, and presents debounced-free, active-high button words to the system's peripheral register interface.
- Sits between the board pins and the NESCTRL peripheral registers read by the RISC-V core.

Parameters:
- DIV, 4, system clocks per protocol phase (tick). Legal range is ≥4 so the 2-FF synchronizer settles before sampling.
- POLL_PERIOD, 100000, system clocks between automatic scans. Must be ≥ 17*DIV+2.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- en  in  1  enables automatic periodic polling
- scan_req  in  1  single-cycle request for an immediate scan; honoured only in IDLE
- nesctrl_ctrl1_q7  in  1  serial data from pad 1 (async, active-low buttons)
- nesctrl_ctrl2_q7  in  1  serial data from pad 2
- nesctrl_pl  out  1  parallel-load pulse to both pads
- nesctrl_clk  out  1  shift clock to both pads (idle low, pads shift on rising edge)
- nesctrl_ctrl1_data  out  8  pad 1 buttons, 1 = pressed
- nesctrl_ctrl2_data  out  8  pad 2 buttons, 1 = pressed
- data_valid  out  1  one-cycle pulse when the data outputs update
- busy  out  1  high while a scan is in progress

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; all outputs 0; poll counter, tick counter, bit index, shift registers and synchronizers cleared. Asserting reset mid-scan aborts the scan immediately and drives nesctrl_pl and nesctrl_clk low.
- Synchronizers: q7 inputs pass through 2-FF synchronizers, then are inverted, so that pressed = 1.
- Bit order: bit0=A, 1=B, 2=Select, 3=Start, 4=Up, 5=Down, 6=Left, 7=Right.
- Poll counter: free-running 0..POLL_PERIOD-1, wraps to 0. A wrap with en=1 in IDLE starts a scan. A wrap while busy is dropped and is not queued.
- Simultaneous wrap and scan_req start exactly one scan.
- FSM:
  - IDLE: busy=0. Goes to LATCH on a start condition.
  - LATCH: pl=1 for 2*DIV cycles, then SAMPLE with idx=0.
  - SAMPLE: pl=0, clk=0 for DIV cycles. On the last cycle, shift register bit idx captures both synchronized inputs. If idx=7, go to DONE; else go to CLK_HI.
  - CLK_HI: nesctrl_clk=1 for DIV cycles, then idx+1 and back to SAMPLE.
  - DONE: one cycle. Outputs load from the shift registers, data_valid=1, then IDLE.
- Outputs are registered. pl and clk are driven from state flops only, so they are glitch-free.
- Latency: from the cycle after the start condition to the data_valid cycle is 2D + 8D + 7D + 1 = 17*DIV+1 clocks. busy is high for that whole window, including DONE.
- Data outputs hold their value between scans and change only in DONE.
- scan_req outside IDLE is ignored.
- en deasserted mid-scan does not abort the scan.

Optional Feature:
- Macro: NESCTRL_DEBOUNCE_EN.
- With the macro defined: each output bit changes only when the same new value is captured in two consecutive scans. Otherwise it keeps its previous value. data_valid still pulses on every DONE. Costs one extra 8-bit previous-scan register per pad; reset clears it.
- Without the macro: outputs take the raw result of every scan.

Test Plan:
- Reset release with en=0, no scan_req for 1000 clocks -> busy=0, pl=0, clk=0, data=0, data_valid never asserted.
- DIV=4, scan_req pulse; behavioural 4021 pads with pad1 pressing A+Start (q7 stream 0,1,1,0,1,1,1,1) and pad2 pressing Right -> pl high exactly 8 clocks, 7 nesctrl_clk pulses 4 clocks wide, data_valid 69 clocks after request, ctrl1_data=8'h09, ctrl2_data=8'h80.
- en=1, POLL_PERIOD=100, DIV=4, constant pads -> data_valid every 100 clocks; outputs stable across scans.
- scan_req asserted while busy and again the same cycle a poll wrap occurs -> only one scan, no back-to-back second scan.
- rst pulled low during CLK_HI of bit 3 -> pl and clk low immediately, data 0, busy 0. After release, the next scan_req produces a complete correct 17*DIV+1 sequence.
- NESCTRL_DEBOUNCE_EN defined, pad1 A pressed for one scan then released -> ctrl1_data stays 8'h00. A held for two scans -> bit0 set on the second data_valid.
